// File: rtl/noc_input_unit_pkg.sv
// Shared types for the NoC input unit: flit preamble, coordinates, directions and XY routing.
package noc_input_unit_pkg;

  localparam int unsigned PreambleWidth    = 2;
  localparam int unsigned XWidth           = 4;
  localparam int unsigned YWidth           = 4;
  localparam int unsigned DefaultDataWidth = 64;

  // Preamble occupies the two MSBs of every flit: {head, tail}.
  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  typedef struct packed {
    logic [YWidth-1:0] y;
    logic [XWidth-1:0] x;
  } xy_t;

  typedef enum logic [4:0] {
    goNorth = 5'b00001,
    goEast  = 5'b00010,
    goSouth = 5'b00100,
    goWest  = 5'b01000,
    goLocal = 5'b10000
  } direction_t;

  typedef enum logic {
    kFlowControlAckNack,
    kFlowControlCreditBased
  } noc_flow_control_t;

  // Flit layout at the default payload width.
  typedef struct packed {
    preamble_t                   p;
    logic [DefaultDataWidth-1:0] payload;
  } flit_t;

  typedef enum logic {
    kIdle,
    kInPacket
  } input_state_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic direction_t xy_route(xy_t pos, xy_t dst);
    direction_t dir;
    if (dst.x > pos.x) begin
      dir = goEast;
    end else if (dst.x < pos.x) begin
      dir = goWest;
    end else if (dst.y > pos.y) begin
      dir = goSouth;
    end else if (dst.y < pos.y) begin
      dir = goNorth;
    end else begin
      dir = goLocal;
    end
    return dir;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and occupancy count.
// Caller only raises push when there is room (or a pop happens in the same cycle).
module noc_sync_fifo #(
  parameter int unsigned Width      = 8,
  parameter int unsigned Depth      = 4,
  localparam int unsigned PtrWidth  = $clog2(Depth),
  localparam int unsigned CntWidth  = PtrWidth + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [Width-1:0]    wdata,
  output logic [Width-1:0]    rdata,
  output logic                full,
  output logic                empty,
  output logic [CntWidth-1:0] count
);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] count_q;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntWidth'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/noc_input_unit.sv
// Router input port: buffers upstream flits, tracks packet framing, computes the XY route of
// the packet at the FIFO head and generates ack/nack or credit flow control.
module noc_input_unit
  import noc_input_unit_pkg::*;
#(
  parameter int unsigned       DataWidth   = 64,
  parameter int unsigned       Depth       = 4,
  parameter noc_flow_control_t FlowControl = kFlowControlCreditBased,
  parameter int unsigned       DestXLsb    = 0,
  parameter int unsigned       DestYLsb    = 4,
  localparam int unsigned      FlitWidth   = DataWidth + PreambleWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  xy_t                  position,
  input  logic [FlitWidth-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 stop_out,
  output logic                 credit_out,
  output logic [FlitWidth-1:0] data_out,
  output logic                 data_out_valid,
  output direction_t           route_out,
  input  logic                 data_out_pop,
  output logic                 overflow_err,
  output logic                 protocol_err
);

  localparam int unsigned          CntWidth  = $clog2(Depth) + 1;
  localparam logic [CntWidth-1:0]  StopLevel = CntWidth'(Depth - 1);

  logic                 full;
  logic                 empty;
  logic [CntWidth-1:0]  count;
  logic [CntWidth-1:0]  count_next;
  logic                 push_ok;
  logic                 pop_ok;
  logic [FlitWidth-1:0] fifo_rdata;
  preamble_t            front;
  xy_t                  front_dst;
  direction_t           front_route;

  input_state_t         state_q;
  direction_t           route_latch_q;
  logic                 stop_q;
  logic                 credit_q;
  logic                 overflow_q;
  logic                 protocol_q;

  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign pop_ok  = data_out_pop & ~empty;
  assign push_ok = data_in_valid & (~full | pop_ok);

  noc_sync_fifo #(
    .Width (FlitWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Force data_out to zero when empty so stale storage never leaks out.
  assign data_out       = empty ? '0 : fifo_rdata;
  assign data_out_valid = ~empty;

  assign front       = preamble_t'(data_out[FlitWidth-1 -: PreambleWidth]);
  assign front_dst.x = data_out[DestXLsb +: XWidth];
  assign front_dst.y = data_out[DestYLsb +: YWidth];
  assign front_route = xy_route(position, front_dst);

  // Occupancy after the coming edge, used for the registered stop decision.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + CntWidth'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count - CntWidth'(1);
    end
  end

  // Fresh route only for a head flit in IDLE; everything else follows the latched route.
  always_comb begin
    route_out = route_latch_q;
    if (state_q == kIdle && data_out_valid && front.head) begin
      route_out = front_route;
    end
  end

  // Packet framing FSM: latch the head's route for the body, release on tail pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= kIdle;
      route_latch_q <= goLocal;
    end else if (pop_ok) begin
      case (state_q)
        kIdle: begin
          if (front.head && !front.tail) begin
            state_q       <= kInPacket;
            route_latch_q <= front_route;
          end
        end
        kInPacket: begin
          if (front.tail) begin
            state_q <= kIdle;
          end
        end
        default: state_q <= kIdle;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      protocol_q <= 1'b0;
    end else begin
      if (data_in_valid && full && !pop_ok) begin
        overflow_q <= 1'b1;
      end
      if (data_out_valid &&
          ((state_q == kIdle && !front.head) || (state_q == kInPacket && front.head))) begin
        protocol_q <= 1'b1;
      end
    end
  end

  // Flow control: stop leaves room for one in-flight flit; credit echoes each pop one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_q   <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      stop_q   <= (FlowControl == kFlowControlAckNack) && (count_next >= StopLevel);
      credit_q <= (FlowControl == kFlowControlCreditBased) && pop_ok;
    end
  end

  assign stop_out     = stop_q;
  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;
  assign protocol_err = protocol_q;

endmodule

// File: tb/tb_noc_input_unit.sv
// Bench for noc_input_unit: one credit-mode and one ack/nack-mode instance share stimulus;
// directed scenarios plus a randomized run checked against a queue-based reference model.
module tb_noc_input_unit;
  import noc_input_unit_pkg::*;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned Depth     = 4;
  localparam int unsigned DestXLsb  = 0;
  localparam int unsigned DestYLsb  = 4;
  localparam int unsigned FlitWidth = DataWidth + PreambleWidth;

  logic                 clk = 1'b0;
  logic                 rst;
  xy_t                  position;
  logic [FlitWidth-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_out_pop;

  logic                 cr_stop, cr_credit, cr_valid, cr_ovf, cr_perr;
  logic [FlitWidth-1:0] cr_data;
  direction_t           cr_route;
  logic                 an_stop, an_credit, an_valid, an_ovf, an_perr;
  logic [FlitWidth-1:0] an_data;
  direction_t           an_route;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  noc_input_unit #(
    .DataWidth(DataWidth), .Depth(Depth), .FlowControl(kFlowControlCreditBased),
    .DestXLsb(DestXLsb), .DestYLsb(DestYLsb)
  ) dut_cr (
    .clk(clk), .rst(rst), .position(position), .data_in(data_in),
    .data_in_valid(data_in_valid), .stop_out(cr_stop), .credit_out(cr_credit),
    .data_out(cr_data), .data_out_valid(cr_valid), .route_out(cr_route),
    .data_out_pop(data_out_pop), .overflow_err(cr_ovf), .protocol_err(cr_perr)
  );

  noc_input_unit #(
    .DataWidth(DataWidth), .Depth(Depth), .FlowControl(kFlowControlAckNack),
    .DestXLsb(DestXLsb), .DestYLsb(DestYLsb)
  ) dut_an (
    .clk(clk), .rst(rst), .position(position), .data_in(data_in),
    .data_in_valid(data_in_valid), .stop_out(an_stop), .credit_out(an_credit),
    .data_out(an_data), .data_out_valid(an_valid), .route_out(an_route),
    .data_out_pop(data_out_pop), .overflow_err(an_ovf), .protocol_err(an_perr)
  );

  // Reference model state
  logic [FlitWidth-1:0] m_q[$];
  bit                   m_in_pkt;
  direction_t           m_lat;
  bit                   m_ovf, m_perr, m_credit, m_stop;

  function automatic direction_t ref_route(xy_t p, logic [FlitWidth-1:0] f);
    int unsigned dx, dy, px, py;
    dx = f[DestXLsb +: XWidth];
    dy = f[DestYLsb +: YWidth];
    px = p.x;
    py = p.y;
    if (dx > px) return goEast;
    if (dx < px) return goWest;
    if (dy > py) return goSouth;
    if (dy < py) return goNorth;
    return goLocal;
  endfunction

  function automatic logic [FlitWidth-1:0] mk_flit(bit head, bit tail, int unsigned x,
                                                   int unsigned y);
    logic [DataWidth-1:0] pl;
    pl = {$urandom, $urandom};
    pl[DestXLsb +: XWidth] = x[XWidth-1:0];
    pl[DestYLsb +: YWidth] = y[YWidth-1:0];
    return {head, tail, pl};
  endfunction

  function automatic direction_t exp_route();
    logic [FlitWidth-1:0] f;
    if (m_q.size() == 0 || m_in_pkt) return m_lat;
    f = m_q[0];
    if (f[FlitWidth-1]) return ref_route(position, f);
    return m_lat;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_in_pkt = 0;
    m_lat    = goLocal;
    m_ovf    = 0;
    m_perr   = 0;
    m_credit = 0;
    m_stop   = 0;
  endtask

  task automatic model_edge(bit v, logic [FlitWidth-1:0] d, bit p);
    bit                   pop_ok, push_ok;
    logic [FlitWidth-1:0] f;
    pop_ok  = p && (m_q.size() > 0);
    push_ok = v && ((m_q.size() < Depth) || pop_ok);
    if (v && m_q.size() == Depth && !pop_ok) m_ovf = 1;
    if (m_q.size() > 0) begin
      f = m_q[0];
      if (m_in_pkt && f[FlitWidth-1]) m_perr = 1;
      if (!m_in_pkt && !f[FlitWidth-1]) m_perr = 1;
    end
    if (pop_ok) begin
      f = m_q.pop_front();
      if (!m_in_pkt) begin
        if (f[FlitWidth-1] && !f[FlitWidth-2]) begin
          m_in_pkt = 1;
          m_lat    = ref_route(position, f);
        end
      end else if (f[FlitWidth-2]) begin
        m_in_pkt = 0;
      end
    end
    if (push_ok) m_q.push_back(d);
    m_credit = pop_ok;
    m_stop   = (m_q.size() >= Depth - 1);
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(bit v, logic [FlitWidth-1:0] d, bit p);
    data_in_valid = v;
    data_in       = d;
    data_out_pop  = p;
    model_edge(v, d, p);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_out_pop  = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    data_in_valid = 1'b0;
    data_out_pop  = 1'b0;
    data_in       = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    position = '{y: 4'd2, x: 4'd2};
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_pop  = 1'b0;
    data_in       = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({cr_valid, cr_stop, cr_credit, cr_ovf, cr_perr} !== 5'b0) begin
      n_miss++;
      $display("FAIL reset_cr_outputs: got %b want 00000",
               {cr_valid, cr_stop, cr_credit, cr_ovf, cr_perr});
    end
    n_vec++;
    if ({an_valid, an_stop, an_credit, an_ovf, an_perr} !== 5'b0) begin
      n_miss++;
      $display("FAIL reset_an_outputs: got %b want 00000",
               {an_valid, an_stop, an_credit, an_ovf, an_perr});
    end
    n_vec++;
    if (cr_route !== goLocal || cr_data !== '0) begin
      n_miss++;
      $display("FAIL reset_route_data: got route %b data %h want %b / 0", cr_route, cr_data,
               goLocal);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_overflow();
    logic [FlitWidth-1:0] fl[5];
    do_reset();
    for (int i = 0; i < 5; i++) fl[i] = mk_flit(1, 1, 3, 3);
    for (int i = 0; i < 4; i++) step(1, fl[i], 0);
    n_vec++;
    if (cr_ovf !== 1'b0 || cr_valid !== 1'b1 || an_stop !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_fill4: got ovf %b valid %b stop %b want 0 1 1", cr_ovf, cr_valid,
               an_stop);
    end
    step(1, fl[4], 0);
    n_vec++;
    if (cr_ovf !== 1'b1 || an_ovf !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_fifth_push: got %b/%b want 1/1", cr_ovf, an_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cr_data !== fl[i]) begin
        n_miss++;
        $display("FAIL ovf_order[%0d]: got %h want %h", i, cr_data, fl[i]);
      end
      step(0, '0, 1);
    end
    n_vec++;
    if (cr_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL ovf_dropped: got valid %b want 0", cr_valid);
    end
  endtask

  task automatic test_credit();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, mk_flit(1, 1, 2, 2), 0);
    n_vec++;
    if (cr_credit !== 1'b0) begin
      n_miss++;
      $display("FAIL credit_before_pop: got %b want 0", cr_credit);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1);
      n_vec++;
      if (cr_credit !== 1'b1 || an_credit !== 1'b0) begin
        n_miss++;
        $display("FAIL credit_pulse[%0d]: got cr %b an %b want 1 0", i, cr_credit, an_credit);
      end
    end
    step(0, '0, 1);  // pop while empty: ignored
    n_vec++;
    if (cr_credit !== 1'b0) begin
      n_miss++;
      $display("FAIL credit_empty_pop: got %b want 0", cr_credit);
    end
  endtask

  task automatic test_stop();
    bit exp_stop[3] = '{0, 0, 1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, mk_flit(1, 1, 1, 1), 0);
      n_vec++;
      if (an_stop !== exp_stop[i] || cr_stop !== 1'b0) begin
        n_miss++;
        $display("FAIL stop_push[%0d]: got an %b cr %b want %b 0", i, an_stop, cr_stop,
                 exp_stop[i]);
      end
    end
    step(0, '0, 1);
    n_vec++;
    if (an_stop !== 1'b0) begin
      n_miss++;
      $display("FAIL stop_release: got %b want 0", an_stop);
    end
  endtask

  task automatic test_routes();
    int unsigned xs[5] = '{5, 0, 2, 2, 2};
    int unsigned ys[5] = '{2, 2, 7, 0, 2};
    direction_t  ex[5] = '{goEast, goWest, goSouth, goNorth, goLocal};
    do_reset();
    position = '{y: 4'd2, x: 4'd2};
    for (int i = 0; i < 5; i++) begin
      step(1, mk_flit(1, 1, xs[i], ys[i]), 0);
      n_vec++;
      if (cr_route !== ex[i] || an_route !== ex[i]) begin
        n_miss++;
        $display("FAIL route[%0d]: got %b want %b", i, cr_route, ex[i]);
      end
      step(0, '0, 1);
    end
  endtask

  task automatic test_packet();
    do_reset();
    position = '{y: 4'd2, x: 4'd2};
    step(1, mk_flit(1, 0, 5, 2), 0);
    step(1, mk_flit(0, 0, 0, 2), 0);
    step(1, mk_flit(0, 0, 0, 2), 0);
    step(1, mk_flit(0, 1, 0, 2), 0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cr_route !== goEast) begin
        n_miss++;
        $display("FAIL pkt_route[%0d]: got %b want %b", i, cr_route, goEast);
      end
      step(0, '0, 1);
    end
    step(1, mk_flit(1, 1, 2, 7), 0);
    n_vec++;
    if (cr_route !== goSouth || cr_perr !== 1'b0) begin
      n_miss++;
      $display("FAIL pkt_next_head: got route %b perr %b want %b 0", cr_route, cr_perr,
               goSouth);
    end
    step(0, '0, 1);
  endtask

  task automatic test_protocol();
    do_reset();
    position = '{y: 4'd2, x: 4'd2};
    step(1, mk_flit(0, 0, 1, 1), 0);
    step(0, '0, 0);
    n_vec++;
    if (cr_perr !== 1'b1 || an_perr !== 1'b1) begin
      n_miss++;
      $display("FAIL perr_body_idle: got %b/%b want 1/1", cr_perr, an_perr);
    end
    step(0, '0, 1);
    step(1, mk_flit(1, 0, 5, 2), 0);
    step(0, '0, 1);
    step(1, mk_flit(0, 0, 0, 2), 0);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({cr_valid, an_valid, cr_perr, an_perr, cr_ovf} !== 5'b0) begin
      n_miss++;
      $display("FAIL midpkt_reset: got %b want 00000",
               {cr_valid, an_valid, cr_perr, an_perr, cr_ovf});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1, mk_flit(1, 1, 0, 2), 0);
    step(0, '0, 0);
    n_vec++;
    if (cr_route !== goWest || cr_valid !== 1'b1 || cr_perr !== 1'b0) begin
      n_miss++;
      $display("FAIL fresh_head: got route %b valid %b perr %b want %b 1 0", cr_route,
               cr_valid, cr_perr, goWest);
    end
    step(0, '0, 1);
  endtask

  task automatic test_random();
    bit                   v, p, h, t, gen_in_pkt;
    logic [FlitWidth-1:0] f;
    do_reset();
    position   = '{y: 4'($urandom_range(0, 7)), x: 4'($urandom_range(0, 7))};
    gen_in_pkt = 0;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom % 2) == 1;
      p = ($urandom % 3) != 0;
      h = !gen_in_pkt;
      t = ($urandom % 3) == 0;
      if (($urandom % 40) == 0) h = !h;  // occasional framing violation
      if (v) gen_in_pkt = !t;
      f = mk_flit(h, t, $urandom_range(0, 7), $urandom_range(0, 7));
      step(v, f, p);
      n_vec++;
      if (cr_valid !== (m_q.size() != 0) || an_valid !== (m_q.size() != 0)) begin
        n_miss++;
        $display("FAIL rnd_valid c%0d: got %b/%b want %b", c, cr_valid, an_valid,
                 m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        n_vec++;
        if (cr_data !== m_q[0] || an_data !== m_q[0]) begin
          n_miss++;
          $display("FAIL rnd_data c%0d: got %h want %h", c, cr_data, m_q[0]);
        end
        n_vec++;
        if (cr_route !== exp_route()) begin
          n_miss++;
          $display("FAIL rnd_route c%0d: got %b want %b", c, cr_route, exp_route());
        end
      end
      n_vec++;
      if (cr_credit !== m_credit || an_stop !== m_stop || an_credit !== 1'b0 ||
          cr_stop !== 1'b0) begin
        n_miss++;
        $display("FAIL rnd_flow c%0d: got credit %b stop %b want %b %b", c, cr_credit,
                 an_stop, m_credit, m_stop);
      end
      n_vec++;
      if (cr_ovf !== m_ovf || an_ovf !== m_ovf || cr_perr !== m_perr ||
          an_perr !== m_perr) begin
        n_miss++;
        $display("FAIL rnd_errs c%0d: got ovf %b perr %b want %b %b", c, cr_ovf, cr_perr,
                 m_ovf, m_perr);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overflow();
    test_credit();
    test_stop();
    test_routes();
    test_packet();
    test_protocol();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
